// File: rtl/gf2m_digit_mul_hs.sv
// Digit-serial GF(2^m) multiply-accumulate, res = (a*b mod f) ^ acc.
// Polynomial basis, runtime poly, valid/ready in and out, abort.
module gf2m_digit_mul_hs #(
  parameter int DW         = 257,
  parameter int DIGIT      = 7,
  parameter int EARLY_EXIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          acc_en,
  input  logic [DW-1:0] acc_in,
  input  logic [DW-1:0] poly,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] res,
  output logic          busy
);

  localparam int N  = (DW + DIGIT - 1) / DIGIT;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] c_q, c_d;
  logic [DW-1:0] f_q, f_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DW-1:0] b_it, c_it, a_nxt;
  logic          accept, last;

  assign in_ready  = (state_q == S_IDLE) |
                     ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready & ~abort;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);
  assign res       = c_q;

  // One iteration: DIGIT add-and-xtime steps chained combinationally
  always_comb begin
    c_it = c_q;
    b_it = b_q;
    for (int i = 0; i < DIGIT; i++) begin
      if (a_q[i]) c_it = c_it ^ b_it;
      b_it = {b_it[DW-2:0], 1'b0} ^ ({DW{b_it[DW-1]}} & f_q);
    end
  end

  assign a_nxt = a_q >> DIGIT;
  assign last  = (cnt_q == CW'(N - 1)) ||
                 ((EARLY_EXIT != 0) && (a_nxt == '0));

  // Next-state: abort wins over accept, accept over iteration
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = S_IDLE;
    end else if (accept) begin
      a_d     = a;
      b_d     = b;
      f_d     = poly;
      c_d     = acc_en ? acc_in : '0;
      cnt_d   = '0;
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      a_d   = a_nxt;
      b_d   = b_it;
      c_d   = c_it;
      cnt_d = cnt_q + CW'(1);
      if (last) state_d = S_DONE;
    end else if ((state_q == S_DONE) && out_ready) begin
      state_d = S_IDLE;
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gf2m_digit_mul_hs.sv
// Bench for gf2m_digit_mul_hs: small 8-bit fixed-latency instance
// plus a default 257-bit early-exit instance.
module tb_gf2m_digit_mul_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 8-bit instance, DIGIT=3, fixed latency
  logic       v8, ir8, ae8, ab8, ov8, ordy8, busy8;
  logic [7:0] a8, b8, acc8, p8, res8;

  gf2m_digit_mul_hs #(.DW(8), .DIGIT(3), .EARLY_EXIT(0)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8),
    .a(a8), .b(b8), .acc_en(ae8), .acc_in(acc8), .poly(p8),
    .abort(ab8), .out_valid(ov8), .out_ready(ordy8),
    .res(res8), .busy(busy8)
  );

  // default instance, early exit
  logic         vL, irL, aeL, abL, ovL, ordyL, busyL;
  logic [256:0] aL, bL, accL, pL, resL;

  gf2m_digit_mul_hs uL (
    .clk(clk), .rst(rst), .in_valid(vL), .in_ready(irL),
    .a(aL), .b(bL), .acc_en(aeL), .acc_in(accL), .poly(pL),
    .abort(abL), .out_valid(ovL), .out_ready(ordyL),
    .res(resL), .busy(busyL)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [256:0] act,
                     input logic [256:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // independent reference: schoolbook product then top-down reduction
  function automatic logic [7:0] gmul8(input logic [7:0] x, y, p);
    logic [14:0] t;
    t = '0;
    for (int i = 0; i < 8; i++)
      if (x[i]) t = t ^ (15'(y) << i);
    for (int k = 14; k >= 8; k--)
      if (t[k]) t = t ^ (15'({1'b1, p}) << (k - 8));
    return t[7:0];
  endfunction

  task automatic op8(input logic [7:0] a, b, acc, p, input logic ae,
                     output logic [7:0] r, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; acc8 = acc; p8 = p; ae8 = ae; v8 = 1'b1;
    chk("in_ready8", ir8, 1);
    @(posedge clk); #1;
    v8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    p8 = 8'($urandom); acc8 = 8'($urandom);
    lat = 0;
    while (!ov8 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    r = res8;
    @(negedge clk); ordy8 = 1'b1;
    @(negedge clk); ordy8 = 1'b0;
  endtask

  task automatic opL(input logic [256:0] a, b, acc, p, input logic ae,
                     output logic [256:0] r, output int lat);
    @(negedge clk);
    aL = a; bL = b; accL = acc; pL = p; aeL = ae; vL = 1'b1;
    @(posedge clk); #1;
    vL = 1'b0;
    aL = '1; bL = '1; pL = '1; accL = '1;
    lat = 0;
    while (!ovL && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    r = resL;
    @(negedge clk); ordyL = 1'b1;
    @(negedge clk); ordyL = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a, b, acc;
    logic       ae;
    logic [7:0] r;
  } vec_t;

  vec_t tv[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   r8, ra, rb, rp;
    logic [256:0] rl;
    logic [256:0] one;
    int           lat, seen;

    one = 257'd1;
    tv[0]  = '{8'h53, 8'hCA, 8'h00, 1'b0, 8'h01};
    tv[1]  = '{8'h57, 8'h83, 8'hFF, 1'b1, 8'h3E};
    tv[2]  = '{8'h57, 8'h13, 8'h00, 1'b0, 8'hFE};
    tv[3]  = '{8'h02, 8'h87, 8'h00, 1'b0, 8'h15};
    tv[4]  = '{8'h00, 8'h55, 8'hA5, 1'b1, 8'hA5};
    tv[5]  = '{8'h01, 8'h57, 8'h00, 1'b0, 8'h57};
    tv[6]  = '{8'h10, 8'h57, 8'h00, 1'b0, 8'h07};
    tv[7]  = '{8'h80, 8'h01, 8'h00, 1'b0, 8'h80};
    tv[8]  = '{8'h80, 8'h80, 8'h00, 1'b0, 8'h9A};
    tv[9]  = '{8'h03, 8'h03, 8'h00, 1'b0, 8'h05};
    tv[10] = '{8'hFF, 8'h01, 8'h0F, 1'b1, 8'hF0};

    rst = 1'b0;
    v8 = 0; ae8 = 0; ab8 = 0; ordy8 = 0;
    a8 = 0; b8 = 0; acc8 = 0; p8 = 0;
    vL = 0; aeL = 0; abL = 0; ordyL = 0;
    aL = 0; bL = 0; accL = 0; pL = 0;

    #3;
    chk("rst_res8", res8, 0);
    chk("rst_ov8", ov8, 0);
    chk("rst_busyL", busyL, 0);
    chk("rst_resL", resL, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_ir8", ir8, 1);
    chk("rel_irL", irL, 1);

    // table vectors, AES field, fixed latency of 3
    for (int i = 0; i < 11; i++) begin
      op8(tv[i].a, tv[i].b, tv[i].acc, 8'h1B, tv[i].ae, r8, lat);
      chk($sformatf("vec%0d_res", i), r8, tv[i].r);
      chk($sformatf("vec%0d_lat", i), lat, 3);
    end

    // random polys against the reference
    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rp = 8'($urandom) | 8'h01;
      op8(ra, rb, 8'h00, rp, 1'b0, r8, lat);
      chk($sformatf("rnd%0d", i), r8, gmul8(ra, rb, rp));
    end

    // wide instance, early exit latencies
    opL(257'd2, one << 256, 0, 257'h1001, 1'b0, rl, lat);
    chk("T3_res", rl, 257'h1001);
    chk("T3_lat", lat, 1);
    opL(257'h80, 257'd1, 0, 257'h1001, 1'b0, rl, lat);
    chk("x7_res", rl, 257'h80);
    chk("x7_lat", lat, 2);
    opL(257'd0, 257'd5, 257'hDEAD, 257'h1001, 1'b1, rl, lat);
    chk("a0_res", rl, 257'hDEAD);
    chk("a0_lat", lat, 1);
    opL(one << 256, 257'd2, 0, 257'h1001, 1'b0, rl, lat);
    chk("msb_res", rl, 257'h1001);
    chk("msb_lat", lat, 37);

    // back-to-back: second op taken on the edge that retires the first
    @(negedge clk);
    aL = 257'd2; bL = one << 256; pL = 257'h1001; aeL = 0; vL = 1'b1;
    @(posedge clk); #1;
    aL = 257'd3; bL = 257'd5; accL = 257'd1; aeL = 1'b1;
    ordyL = 1'b1;
    lat = 0;
    while (!ovL && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk("b2b_res1", resL, 257'h1001);
    chk("b2b_ir", irL, 1);
    @(posedge clk); #1;
    chk("b2b_ovdrop", ovL, 0);
    chk("b2b_busy", busyL, 1);
    vL = 1'b0; ordyL = 1'b0;
    lat = 0;
    while (!ovL && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk("b2b_res2", resL, 257'hE);
    @(negedge clk); ordyL = 1'b1;
    @(negedge clk); ordyL = 1'b0;

    // abort five edges into a long run, with in_valid held high
    @(negedge clk);
    aL = one << 256; bL = 257'd1; pL = 257'h1001; aeL = 0; vL = 1'b1;
    @(posedge clk); #1;
    chk("ab_busy", busyL, 1);
    repeat (5) @(posedge clk);
    #1 abL = 1'b1;
    @(posedge clk); #1;
    chk("ab_idle", busyL, 0);
    chk("ab_ov", ovL, 0);
    chk("ab_ir", irL, 1);
    abL = 1'b0; vL = 1'b0;
    seen = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (ovL) seen++;
    end
    chk("ab_noval", seen, 0);
    opL(257'd2, one << 256, 0, 257'h1001, 1'b0, rl, lat);
    chk("ab_next", rl, 257'h1001);

    // async reset in the middle of a run
    @(negedge clk);
    aL = one << 256; bL = 257'd1; accL = 257'h1234; aeL = 1'b1;
    pL = 257'h1001; vL = 1'b1;
    @(posedge clk); #1;
    vL = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rs_ov", ovL, 0);
    chk("rs_res", resL, 0);
    chk("rs_busy", busyL, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rs_ir", irL, 1);
    opL(257'd3, 257'd3, 0, 257'h1001, 1'b0, rl, lat);
    chk("rs_next", rl, 257'd5);
    chk("rs_lat", lat, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
